// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: controller state
// encoding and the default register-address width.
package pipe_hazard_ctrl_pkg;

  localparam int DEF_REG_AW = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FPU_BUSY = 2'd1
  } ctrl_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle.
// slave  : the controller (sees ID/EX status and FPU done, drives pipe controls)
// master : the datapath side (drives status, consumes controls)
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_fp;
  logic              id_rs2_fp;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              ex_valid;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_rd_fp;
  logic              ex_wr_en;
  logic              ex_is_load;
  logic              ex_fpu_multi;
  logic              ex_redirect;
  logic              fpu_done;
  logic              freeze;
  logic              stall_fe;
  logic              bubble;
  logic              flush;
  logic              fpu_start;
  logic              fpu_busy;
  logic              err_timeout;

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_fp, id_rs2_fp, id_use_rs1, id_use_rs2,
    input  ex_valid, ex_rd, ex_rd_fp, ex_wr_en, ex_is_load, ex_fpu_multi, ex_redirect,
    input  fpu_done,
    output freeze, stall_fe, bubble, flush, fpu_start, fpu_busy, err_timeout
  );

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_fp, id_rs2_fp, id_use_rs1, id_use_rs2,
    output ex_valid, ex_rd, ex_rd_fp, ex_wr_en, ex_is_load, ex_fpu_multi, ex_redirect,
    output fpu_done,
    input  freeze, stall_fe, bubble, flush, fpu_start, fpu_busy, err_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl_match.sv
// Compares one ID source operand against the EX destination.
// Ports: rs/rs_fp/use_rs describe the source operand; ex_* describe the EX
// writer; match is high when the source depends on the EX result.
module pipe_hazard_ctrl_match
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_fp,
  input  logic              use_rs,
  input  logic              ex_valid,
  input  logic              ex_wr_en,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_rd_fp,
  output logic              match
);
  logic int_x0;

  // x0 in the integer file is hardwired zero; f0 is a real register.
  assign int_x0 = !rs_fp && (rs == '0);

  assign match = use_rs && ex_valid && ex_wr_en && (rs == ex_rd) &&
                 (rs_fp == ex_rd_fp) && !int_x0;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use stall, redirect flush and multi-cycle FPU
// handshake with watchdog.
// Ports: clk, rst_n (async active-low), bus (slave side of the pipe bundle).
//
// state    | meaning
// RUN      | normal flow; hazards and redirects resolved combinationally
// FPU_BUSY | waiting for fpu_done; whole pipe frozen, watchdog counting
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW      = DEF_REG_AW,
  parameter int FPU_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipe_hazard_ctrl_if.slave    bus
);
  ctrl_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic             match_rs1;
  logic             match_rs2;
  logic             load_use;
  logic             fpu_go;
  logic             timeout_hit;

  pipe_hazard_ctrl_match #(.REG_AW(REG_AW)) u_match_rs1 (
    .rs       (bus.id_rs1),
    .rs_fp    (bus.id_rs1_fp),
    .use_rs   (bus.id_use_rs1),
    .ex_valid (bus.ex_valid),
    .ex_wr_en (bus.ex_wr_en),
    .ex_rd    (bus.ex_rd),
    .ex_rd_fp (bus.ex_rd_fp),
    .match    (match_rs1)
  );

  pipe_hazard_ctrl_match #(.REG_AW(REG_AW)) u_match_rs2 (
    .rs       (bus.id_rs2),
    .rs_fp    (bus.id_rs2_fp),
    .use_rs   (bus.id_use_rs2),
    .ex_valid (bus.ex_valid),
    .ex_wr_en (bus.ex_wr_en),
    .ex_rd    (bus.ex_rd),
    .ex_rd_fp (bus.ex_rd_fp),
    .match    (match_rs2)
  );

  assign load_use    = bus.id_valid && bus.ex_is_load && (match_rs1 || match_rs2);
  assign fpu_go      = bus.ex_valid && bus.ex_fpu_multi;
  assign timeout_hit = (cnt == CNT_W'(FPU_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (fpu_go) begin
            state <= FPU_BUSY;
            cnt   <= CNT_W'(1);
          end
        end
        FPU_BUSY: begin
          // A done landing on the timeout cycle still counts as a good result.
          if (bus.fpu_done) begin
            state <= RUN;
            cnt   <= '0;
          end else if (timeout_hit) begin
            state <= RUN;
            cnt   <= '0;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Controls are gated by rst_n so the pipe sees no action while reset is held,
  // whatever the datapath status inputs are doing.
  always_comb begin
    bus.freeze    = 1'b0;
    bus.stall_fe  = 1'b0;
    bus.bubble    = 1'b0;
    bus.flush     = 1'b0;
    bus.fpu_start = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (fpu_go) begin
            bus.fpu_start = 1'b1;
            bus.freeze    = 1'b1;
          end else if (bus.ex_redirect) begin
            bus.flush  = 1'b1;
            bus.bubble = 1'b1;
          end else if (load_use) begin
            bus.stall_fe = 1'b1;
            bus.bubble   = 1'b1;
          end
        end
        FPU_BUSY: bus.freeze = !bus.fpu_done && !timeout_hit;
        default: ;
      endcase
    end
  end

  assign bus.fpu_busy    = (state == FPU_BUSY);
  assign bus.err_timeout = err;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(5)) a ();
  pipe_hazard_ctrl_if #(.REG_AW(5)) b ();

  pipe_hazard_ctrl #(.REG_AW(5), .FPU_TIMEOUT(64), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .bus(a.slave)
  );
  pipe_hazard_ctrl #(.REG_AW(5), .FPU_TIMEOUT(8), .CNT_W(7)) dut_to (
    .clk(clk), .rst_n(rst_n), .bus(b.slave)
  );

  // {freeze, stall_fe, bubble, flush, fpu_start}
  function automatic logic [4:0] ctl_a();
    return {a.freeze, a.stall_fe, a.bubble, a.flush, a.fpu_start};
  endfunction
  function automatic logic [4:0] ctl_b();
    return {b.freeze, b.stall_fe, b.bubble, b.flush, b.fpu_start};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a.id_valid = 0; a.id_rs1 = 0; a.id_rs2 = 0; a.id_rs1_fp = 0; a.id_rs2_fp = 0;
    a.id_use_rs1 = 0; a.id_use_rs2 = 0; a.ex_valid = 0; a.ex_rd = 0; a.ex_rd_fp = 0;
    a.ex_wr_en = 0; a.ex_is_load = 0; a.ex_fpu_multi = 0; a.ex_redirect = 0; a.fpu_done = 0;
  endtask

  task automatic idle_b();
    b.id_valid = 0; b.id_rs1 = 0; b.id_rs2 = 0; b.id_rs1_fp = 0; b.id_rs2_fp = 0;
    b.id_use_rs1 = 0; b.id_use_rs2 = 0; b.ex_valid = 0; b.ex_rd = 0; b.ex_rd_fp = 0;
    b.ex_wr_en = 0; b.ex_is_load = 0; b.ex_fpu_multi = 0; b.ex_redirect = 0; b.fpu_done = 0;
  endtask

  task automatic rand_a();
    a.id_valid = 1'($urandom_range(1)); a.id_rs1 = 5'($urandom_range(31));
    a.id_rs2 = 5'($urandom_range(31)); a.id_rs1_fp = 1'($urandom_range(1));
    a.id_rs2_fp = 1'($urandom_range(1)); a.id_use_rs1 = 1'($urandom_range(1));
    a.id_use_rs2 = 1'($urandom_range(1)); a.ex_valid = 1'($urandom_range(1));
    a.ex_rd = 5'($urandom_range(31)); a.ex_rd_fp = 1'($urandom_range(1));
    a.ex_wr_en = 1'($urandom_range(1)); a.ex_is_load = 1'($urandom_range(1));
    a.ex_fpu_multi = 1'($urandom_range(1)); a.ex_redirect = 1'($urandom_range(1));
    a.fpu_done = 1'($urandom_range(1));
  endtask

  // EX load writing rd; ID reads rs2 only.
  task automatic set_load_use(input logic [4:0] rd, input logic rd_fp,
                              input logic [4:0] rs2, input logic rs2_fp);
    idle_a();
    a.ex_valid = 1; a.ex_wr_en = 1; a.ex_is_load = 1; a.ex_rd = rd; a.ex_rd_fp = rd_fp;
    a.id_valid = 1; a.id_rs1 = 5'd3; a.id_use_rs1 = 1; a.id_rs2 = rs2;
    a.id_rs2_fp = rs2_fp; a.id_use_rs2 = 1;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      rand_a();
      b.ex_valid = 1; b.ex_fpu_multi = 1; b.ex_redirect = 1;
      #1;
      got = {ctl_a(), a.fpu_busy, a.err_timeout};
      n_cmp++;
      if (got !== 7'b0) begin
        n_bad++; $display("FAIL reset_hold_a[%0d]: got %b expected %b", i, got, 7'b0);
      end
      got = {ctl_b(), b.fpu_busy, b.err_timeout};
      n_cmp++;
      if (got !== 7'b0) begin
        n_bad++; $display("FAIL reset_hold_b[%0d]: got %b expected %b", i, got, 7'b0);
      end
    end
    idle_a(); idle_b();
    tick();
    rst_n = 1;
    #1;
    got = {ctl_a(), a.fpu_busy, a.err_timeout};
    n_cmp++;
    if (got !== 7'b0) begin
      n_bad++; $display("FAIL reset_release: got %b expected %b", got, 7'b0);
    end
    tick();
    n_cmp++;
    if (a.fpu_busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_run_state: busy got %b expected 0", a.fpu_busy);
    end
  endtask

  task automatic test_load_use();
    tick();
    set_load_use(5'd5, 0, 5'd5, 0);
    #1;
    n_cmp++;
    if (ctl_a() !== 5'b01100) begin
      n_bad++; $display("FAIL lu_x5: got %b expected %b", ctl_a(), 5'b01100);
    end
    // Bubble now sits in EX: no repeat.
    tick();
    a.ex_valid = 0; a.ex_wr_en = 0; a.ex_is_load = 0;
    #1;
    n_cmp++;
    if (ctl_a() !== 5'b00000) begin
      n_bad++; $display("FAIL lu_once: got %b expected %b", ctl_a(), 5'b00000);
    end
    tick();
    set_load_use(5'd0, 0, 5'd0, 0);
    #1;
    n_cmp++;
    if (ctl_a() !== 5'b00000) begin
      n_bad++; $display("FAIL lu_x0: got %b expected %b", ctl_a(), 5'b00000);
    end
    tick();
    set_load_use(5'd5, 1, 5'd5, 0);
    #1;
    n_cmp++;
    if (ctl_a() !== 5'b00000) begin
      n_bad++; $display("FAIL lu_file_mismatch: got %b expected %b", ctl_a(), 5'b00000);
    end
    tick();
    set_load_use(5'd0, 1, 5'd0, 1);
    #1;
    n_cmp++;
    if (ctl_a() !== 5'b01100) begin
      n_bad++; $display("FAIL lu_f0: got %b expected %b", ctl_a(), 5'b01100);
    end
    tick();
    set_load_use(5'd7, 0, 5'd9, 0);
    a.id_rs1 = 5'd7;
    #1;
    n_cmp++;
    if (ctl_a() !== 5'b01100) begin
      n_bad++; $display("FAIL lu_rs1: got %b expected %b", ctl_a(), 5'b01100);
    end
    tick();
    set_load_use(5'd5, 0, 5'd5, 0);
    a.ex_is_load = 0;
    #1;
    n_cmp++;
    if (ctl_a() !== 5'b00000) begin
      n_bad++; $display("FAIL lu_not_load: got %b expected %b", ctl_a(), 5'b00000);
    end
    tick();
    set_load_use(5'd5, 0, 5'd5, 0);
    a.id_use_rs2 = 0;
    #1;
    n_cmp++;
    if (ctl_a() !== 5'b00000) begin
      n_bad++; $display("FAIL lu_unused_rs2: got %b expected %b", ctl_a(), 5'b00000);
    end
    tick();
    idle_a();
  endtask

  task automatic test_fpu_op();
    int frz;
    frz = 0;
    tick();
    idle_a();
    a.ex_valid = 1; a.ex_fpu_multi = 1; a.ex_wr_en = 1; a.ex_rd = 5'd4; a.ex_rd_fp = 1;
    #1;
    n_cmp++;
    if ({ctl_a(), a.fpu_busy} !== 6'b100010) begin
      n_bad++; $display("FAIL fpu_start: got %b expected %b", {ctl_a(), a.fpu_busy}, 6'b100010);
    end
    if (a.freeze) frz++;
    for (int i = 1; i < 10; i++) begin
      tick();
      // Redirect and a load-use pattern must be ignored while busy.
      a.ex_redirect = 1; a.ex_is_load = 1; a.id_valid = 1; a.id_rs1 = 5'd4;
      a.id_rs1_fp = 1; a.id_use_rs1 = 1;
      #1;
      if (a.freeze) frz++;
      n_cmp++;
      if ({ctl_a(), a.fpu_busy} !== 6'b100001) begin
        n_bad++; $display("FAIL fpu_busy_cyc%0d: got %b expected %b", i, {ctl_a(), a.fpu_busy}, 6'b100001);
      end
    end
    tick();
    a.fpu_done = 1;
    #1;
    n_cmp++;
    if ({ctl_a(), a.fpu_busy} !== 6'b000001) begin
      n_bad++; $display("FAIL fpu_done_cycle: got %b expected %b", {ctl_a(), a.fpu_busy}, 6'b000001);
    end
    n_cmp++;
    if (frz !== 10) begin
      n_bad++; $display("FAIL fpu_freeze_len: got %0d expected %0d", frz, 10);
    end
    tick();
    idle_a();
    #1;
    n_cmp++;
    if ({ctl_a(), a.fpu_busy, a.err_timeout} !== 7'b0) begin
      n_bad++; $display("FAIL fpu_after_done: got %b expected %b", {ctl_a(), a.fpu_busy, a.err_timeout}, 7'b0);
    end
  endtask

  task automatic test_timeout();
    int frz;
    frz = 0;
    tick();
    idle_b();
    b.ex_valid = 1; b.ex_fpu_multi = 1;
    #1;
    if (b.freeze) frz++;
    n_cmp++;
    if ({ctl_b(), b.fpu_busy} !== 6'b100010) begin
      n_bad++; $display("FAIL to_start: got %b expected %b", {ctl_b(), b.fpu_busy}, 6'b100010);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      if (b.freeze) frz++;
    end
    tick();
    #1;
    // cnt == 8: freeze drops, error not yet registered.
    n_cmp++;
    if ({b.freeze, b.fpu_busy, b.err_timeout} !== 3'b010) begin
      n_bad++; $display("FAIL to_hit_cycle: got %b expected %b", {b.freeze, b.fpu_busy, b.err_timeout}, 3'b010);
    end
    n_cmp++;
    if (frz !== 8) begin
      n_bad++; $display("FAIL to_freeze_len: got %0d expected %0d", frz, 8);
    end
    tick();
    idle_b();
    #1;
    n_cmp++;
    if ({ctl_b(), b.fpu_busy, b.err_timeout} !== 7'b0000001) begin
      n_bad++; $display("FAIL to_err_set: got %b expected %b", {ctl_b(), b.fpu_busy, b.err_timeout}, 7'b0000001);
    end
    tick();
    b.fpu_done = 1;
    #1;
    n_cmp++;
    if ({ctl_b(), b.fpu_busy, b.err_timeout} !== 7'b0000001) begin
      n_bad++; $display("FAIL to_late_done: got %b expected %b", {ctl_b(), b.fpu_busy, b.err_timeout}, 7'b0000001);
    end
    tick();
    idle_b();
    #1;
    n_cmp++;
    if ({b.fpu_busy, b.err_timeout} !== 2'b01) begin
      n_bad++; $display("FAIL to_err_sticky: got %b expected %b", {b.fpu_busy, b.err_timeout}, 2'b01);
    end
  endtask

  task automatic test_priority();
    tick();
    set_load_use(5'd5, 0, 5'd5, 0);
    a.ex_redirect = 1;
    #1;
    n_cmp++;
    if (ctl_a() !== 5'b00110) begin
      n_bad++; $display("FAIL prio_redirect_lu: got %b expected %b", ctl_a(), 5'b00110);
    end
    tick();
    set_load_use(5'd5, 0, 5'd5, 0);
    a.ex_redirect = 1; a.ex_fpu_multi = 1;
    #1;
    n_cmp++;
    if (ctl_a() !== 5'b10001) begin
      n_bad++; $display("FAIL prio_fpu_redirect: got %b expected %b", ctl_a(), 5'b10001);
    end
    tick();
    a.fpu_done = 1;
    #1;
    n_cmp++;
    if ({ctl_a(), a.fpu_busy} !== 6'b000001) begin
      n_bad++; $display("FAIL prio_done: got %b expected %b", {ctl_a(), a.fpu_busy}, 6'b000001);
    end
    tick();
    idle_a();
  endtask

  task automatic test_reset_mid_op();
    tick();
    idle_a();
    a.ex_valid = 1; a.ex_fpu_multi = 1;
    for (int i = 0; i < 3; i++) tick();
    #1;
    n_cmp++;
    if ({a.freeze, a.fpu_busy} !== 2'b11) begin
      n_bad++; $display("FAIL mid_busy: got %b expected %b", {a.freeze, a.fpu_busy}, 2'b11);
    end
    rst_n = 0;
    #1;
    n_cmp++;
    if ({a.freeze, a.fpu_busy} !== 2'b00) begin
      n_bad++; $display("FAIL mid_async_reset: got %b expected %b", {a.freeze, a.fpu_busy}, 2'b00);
    end
    n_cmp++;
    if (b.err_timeout !== 1'b0) begin
      n_bad++; $display("FAIL mid_err_cleared: got %b expected 0", b.err_timeout);
    end
    a.ex_fpu_multi = 0;
    tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      n_cmp++;
      if ({ctl_a(), a.fpu_busy} !== 6'b0) begin
        n_bad++; $display("FAIL mid_no_restart[%0d]: got %b expected %b", i, {ctl_a(), a.fpu_busy}, 6'b0);
      end
    end
    tick();
    a.ex_fpu_multi = 1;
    #1;
    n_cmp++;
    if (ctl_a() !== 5'b10001) begin
      n_bad++; $display("FAIL mid_new_start: got %b expected %b", ctl_a(), 5'b10001);
    end
    tick();
    a.fpu_done = 1;
    tick();
    idle_a();
    #1;
    n_cmp++;
    if (a.fpu_busy !== 1'b0) begin
      n_bad++; $display("FAIL mid_final_idle: busy got %b expected 0", a.fpu_busy);
    end
  endtask

  initial begin
    idle_a();
    idle_b();
    test_reset();
    test_load_use();
    test_fpu_op();
    test_timeout();
    test_priority();
    test_reset_mid_op();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
